// File: rtl/fpga_robots_game_alert_pkg.sv
// Shared definitions for the multi-channel game alert block: controller
// state encoding and the default per-channel alert settings.
package fpga_robots_game_alert_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } alert_state_t;

    // Default alert settings (durations in video frames)
    localparam int         DUR_SHORT_BEEP = 15;
    localparam int         DUR_LONG_BEEP  = 45;
    localparam logic [7:0] PAT_DEFAULT    = 8'hFF;

endpackage

// File: rtl/fpga_robots_game_alert_tone.sv
// Tick-driven square-wave generator for the alert audio. The half-period is
// div+1 ticks; restart clears the phase so every alert begins identically.
module fpga_robots_game_alert_tone #(
    parameter int TONEW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             tick,
    input  logic [TONEW-1:0] div,
    output logic             sq
);

    logic [TONEW-1:0] cnt;

    // Count ticks; on reaching div, wrap to zero and flip the square wave
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= '0;
            sq  <= 1'b0;
        end else if (tick) begin
            if (cnt == div) begin
                cnt <= '0;
                sq  <= ~sq;
            end else begin
                cnt <= cnt + TONEW'(1);
            end
        end
    end

endmodule

// File: rtl/fpga_robots_game_alert.sv
// Multi-channel alert controller: fixed-priority arbitration of alert
// requests, frame-paced blink cadence and a tick-paced square-wave tone.
module fpga_robots_game_alert
    import fpga_robots_game_alert_pkg::*;
#(
    parameter int NCHAN = 4,
    parameter int DURW  = 6,
    parameter int PATW  = 8,
    parameter int TONEW = 8,
    parameter int CHW   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame,
    input  logic                   tick,
    input  logic [NCHAN-1:0]       req,
    input  logic [NCHAN*DURW-1:0]  cfg_dur,
    input  logic [NCHAN*PATW-1:0]  cfg_pat,
    input  logic [NCHAN*TONEW-1:0] cfg_div,
    output logic                   attention,
    output logic                   audio,
    output logic                   busy,
    output logic [CHW-1:0]         active_chan,
    output logic                   done,
    output logic [CHW-1:0]         done_chan
);

    // Index of the lowest set bit (channel 0 has the highest priority)
    function automatic logic [CHW-1:0] lowest_set(input logic [NCHAN-1:0] v);
        logic [CHW-1:0] idx;
        idx = '0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (v[i]) idx = CHW'(i);
        end
        return idx;
    endfunction

    alert_state_t     state;
    logic [NCHAN-1:0] pending;
    logic [CHW-1:0]   chan_reg;
    logic [DURW-1:0]  dur_ctr;
    logic [PATW-1:0]  pat_reg;
    logic [TONEW-1:0] div_reg;
    logic             tone_sq;

    logic [NCHAN-1:0] dur_zero, eff_req, discard, lower_mask, preempt;
    logic [NCHAN-1:0] idle_cand, set_mask, pend_next;
    logic             start, retrig, load, step, fin;
    logic [CHW-1:0]   start_chan, sel_chan;
    logic [DURW-1:0]  sel_dur;
    logic [PATW-1:0]  sel_pat;
    logic [TONEW-1:0] sel_div;

    // Request qualification, arbitration and next pending set
    always_comb begin
        for (int i = 0; i < NCHAN; i++) begin
            dur_zero[i]   = (cfg_dur[i*DURW +: DURW] == '0);
            lower_mask[i] = (CHW'(i) < chan_reg);
        end
        // A zero-duration request is dropped outright and cancels any pending one
        eff_req   = req & ~dur_zero;
        discard   = req & dur_zero;
        preempt   = (state != ST_IDLE) ? (eff_req & lower_mask) : '0;
        idle_cand = (state == ST_IDLE) ? (pending & ~discard) : '0;
        start      = (|preempt) || (|idle_cand);
        start_chan = (|preempt) ? lowest_set(preempt) : lowest_set(idle_cand);
        retrig     = (state == ST_PLAY) && !start && eff_req[chan_reg];
        // While playing, a request for the current channel is a re-trigger
        // (or, when preempted in the same cycle, is lost with the aborted alert)
        set_mask = eff_req;
        if (state == ST_PLAY) set_mask[chan_reg] = 1'b0;
        pend_next = (pending | set_mask) & ~discard;
        if (start) pend_next[start_chan] = 1'b0;
        sel_chan = start ? start_chan : chan_reg;
        sel_dur  = cfg_dur[sel_chan*DURW +: DURW];
        sel_pat  = cfg_pat[sel_chan*PATW +: PATW];
        sel_div  = cfg_div[sel_chan*TONEW +: TONEW];
        load = start || retrig;
        step = (state == ST_PLAY) && frame && !load;
        fin  = step && (dur_ctr <= DURW'(1));
    end

    // Controller state, pending requests and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pending   <= '0;
            chan_reg  <= '0;
            done      <= 1'b0;
            done_chan <= '0;
            attention <= 1'b0;
            audio     <= 1'b0;
        end else begin
            pending   <= pend_next;
            done      <= 1'b0;
            attention <= (state == ST_PLAY) && pat_reg[0];
            audio     <= tone_sq && attention && (div_reg != '0);
            if (start) begin
                state    <= ST_PLAY;
                chan_reg <= start_chan;
            end else if (fin) begin
                done      <= 1'b1;
                done_chan <= chan_reg;
                state     <= (|pend_next) ? ST_GAP : ST_IDLE;
            end else if (state == ST_GAP && frame) begin
                state <= ST_IDLE;
            end
        end
    end

    // Per-alert datapath: duration countdown, cadence rotation, tone divider
    always_ff @(posedge clk) begin
        if (load) begin
            dur_ctr <= sel_dur;
            pat_reg <= sel_pat;
        end else if (step) begin
            dur_ctr <= (dur_ctr <= DURW'(1)) ? '0 : dur_ctr - DURW'(1);
            pat_reg <= {pat_reg[0], pat_reg[PATW-1:1]};
        end
        if (start) div_reg <= sel_div;
    end

    assign busy        = (state != ST_IDLE);
    assign active_chan = chan_reg;

    fpga_robots_game_alert_tone #(
        .TONEW(TONEW)
    ) u_tone (
        .clk    (clk),
        .rst    (rst),
        .restart(start),
        .tick   (tick),
        .div    (div_reg),
        .sq     (tone_sq)
    );

endmodule

// File: tb/tb_fpga_robots_game_alert.sv
// Self-checking bench for fpga_robots_game_alert: table-driven single alerts,
// hand-written multi-cycle sequences and a randomized run, all shadowed by a
// cycle-level behavioural model.
module tb_fpga_robots_game_alert;
    import fpga_robots_game_alert_pkg::*;

    localparam int NCHAN = 4;
    localparam int DURW  = 6;
    localparam int PATW  = 8;
    localparam int TONEW = 8;
    localparam int CHW   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame = 1'b0;
    logic tick = 1'b0;
    logic [NCHAN-1:0] req = '0;
    logic [NCHAN*DURW-1:0]  cfg_dur = '0;
    logic [NCHAN*PATW-1:0]  cfg_pat = '0;
    logic [NCHAN*TONEW-1:0] cfg_div = '0;
    logic attention, audio, busy, done;
    logic [CHW-1:0] active_chan, done_chan;

    fpga_robots_game_alert #(
        .NCHAN(NCHAN), .DURW(DURW), .PATW(PATW), .TONEW(TONEW), .CHW(CHW)
    ) dut (
        .clk(clk), .rst(rst), .frame(frame), .tick(tick), .req(req),
        .cfg_dur(cfg_dur), .cfg_pat(cfg_pat), .cfg_div(cfg_div),
        .attention(attention), .audio(audio), .busy(busy),
        .active_chan(active_chan), .done(done), .done_chan(done_chan)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cycle_no = 0;
    int att_frames = 0;
    int done_q[$];

    // Configuration as last written to the buses
    int c_dur[NCHAN];
    int c_pat[NCHAN];
    int c_div[NCHAN];

    // Behavioural model: mode 0 idle, 1 playing, 2 gap
    int m_mode, m_chan, m_left, m_step, m_pat, m_div, m_ticks, m_done_chan;
    logic [NCHAN-1:0] m_pend;
    bit m_att, m_aud, m_done;

    typedef struct {
        int chan; int dur; int pat; int div;
        int exp_att; int exp_aud; int exp_done; int exp_busy;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_cfg(input int ch, input int dur, input int pat, input int div);
        c_dur[ch] = dur; c_pat[ch] = pat; c_div[ch] = div;
        cfg_dur[ch*DURW +: DURW]   = DURW'(dur);
        cfg_pat[ch*PATW +: PATW]   = PATW'(pat);
        cfg_div[ch*TONEW +: TONEW] = TONEW'(div);
    endtask

    task automatic model_step(input logic [NCHAN-1:0] r, input logic f,
                              input logic t, input logic rs);
        logic [NCHAN-1:0] valid, disc, p;
        bit n_att, n_aud;
        int st;
        if (rs) begin
            m_mode = 0; m_chan = 0; m_pend = '0; m_att = 0; m_aud = 0;
            m_done = 0; m_done_chan = 0; m_ticks = 0;
            return;
        end
        for (int i = 0; i < NCHAN; i++) begin
            valid[i] = r[i] && (c_dur[i] != 0);
            disc[i]  = r[i] && (c_dur[i] == 0);
        end
        n_att = (m_mode == 1) && (((m_pat >> (m_step % PATW)) & 1) == 1);
        n_aud = m_att && (m_div != 0) && (((m_ticks / (m_div + 1)) % 2) == 1);
        st = -1;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (m_mode == 0 && m_pend[i] && !disc[i]) st = i;
            if (m_mode != 0 && valid[i] && i < m_chan) st = i;
        end
        p = m_pend;
        for (int i = 0; i < NCHAN; i++) begin
            if (valid[i] && !(m_mode == 1 && i == m_chan)) p[i] = 1'b1;
            if (disc[i]) p[i] = 1'b0;
        end
        m_att = n_att; m_aud = n_aud; m_done = 0;
        if (st >= 0) begin
            p[st] = 1'b0;
            m_mode = 1; m_chan = st; m_left = c_dur[st]; m_step = 0;
            m_pat = c_pat[st]; m_div = c_div[st]; m_ticks = 0;
        end else begin
            if (t) m_ticks++;
            if (m_mode == 1 && valid[m_chan]) begin
                m_left = c_dur[m_chan]; m_step = 0; m_pat = c_pat[m_chan];
            end else if (m_mode == 1 && f) begin
                if (m_left <= 1) begin
                    m_done = 1; m_done_chan = m_chan; m_left = 0;
                    m_mode = (p != '0) ? 2 : 0;
                end else begin
                    m_left--; m_step++;
                end
            end else if (m_mode == 2 && f) begin
                m_mode = 0;
            end
        end
        m_pend = p;
    endtask

    // One clock: drive inputs, advance model, compare all outputs after the edge
    task automatic cyc(input logic [NCHAN-1:0] r, input logic f,
                       input logic t, input logic rs);
        logic [7:0] act, exp;
        req = r; frame = f; tick = t; rst = rs;
        if (f && attention) att_frames++;
        model_step(r, f, t, rs);
        @(posedge clk);
        #1;
        cycle_no++;
        exp = {2'b0, m_att, m_aud, (m_mode != 0), CHW'(m_chan), m_done};
        act = {2'b0, attention, audio, busy, active_chan, done};
        total++;
        if (act !== exp || (m_done && done_chan !== CHW'(m_done_chan))) begin
            bad++;
            $display("FAIL model cyc=%0d got att/aud/busy/chan/done=%b dchan=%0d expected %b dchan=%0d",
                     cycle_no, act[5:0], done_chan, exp[5:0], m_done_chan);
        end
        if (done) done_q.push_back(int'(done_chan));
        req = '0; frame = 1'b0; tick = 1'b0; rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int budget;
        bit aud_seen, busy_seen;
        set_cfg(v.chan, v.dur, v.pat, v.div);
        att_frames = 0; aud_seen = 0; busy_seen = 0; done_q.delete();
        cyc(NCHAN'(1 << v.chan), 1'b0, 1'b1, 1'b0);
        budget = v.dur * 8 + 40;
        for (int k = 0; k < budget; k++) begin
            cyc('0, (k % 8) == 7, 1'b1, 1'b0);
            if (busy) busy_seen = 1;
            if (audio) aud_seen = 1;
            if (done_q.size() > 0 && !busy) break;
        end
        chk($sformatf("vec%0d_att_frames", idx), att_frames, v.exp_att);
        chk($sformatf("vec%0d_audio", idx), int'(aud_seen), v.exp_aud);
        chk($sformatf("vec%0d_done_cnt", idx), done_q.size(), v.exp_done);
        chk($sformatf("vec%0d_busy", idx), int'(busy_seen), v.exp_busy);
        if (v.exp_done == 1 && done_q.size() == 1)
            chk($sformatf("vec%0d_done_chan", idx), done_q[0], v.chan);
    endtask

    initial begin
        int gap_frames, nfr;
        bit found;
        logic [7:0] shape;

        vecs[0] = '{2, DUR_SHORT_BEEP, int'(PAT_DEFAULT), 0, 15, 0, 1, 1};
        vecs[1] = '{1, 16, 'h0F, 0, 8, 0, 1, 1};
        vecs[2] = '{3, 8, 'hFF, 3, 8, 1, 1, 1};
        vecs[3] = '{0, 8, 'h00, 3, 0, 0, 1, 1};
        vecs[4] = '{1, 0, 'hFF, 0, 0, 0, 0, 0};
        vecs[5] = '{0, 63, 'hFF, 0, 63, 0, 1, 1};
        vecs[6] = '{2, 6, 'hAA, 0, 3, 0, 1, 1};
        vecs[7] = '{1, DUR_LONG_BEEP, int'(PAT_DEFAULT), 1, 45, 1, 1, 1};

        for (int i = 0; i < NCHAN; i++) set_cfg(i, 4, 'hFF, 0);

        // Reset state
        cyc('0, 1'b0, 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b0, 1'b1);
        chk("rst_attention", int'(attention), 0);
        chk("rst_audio", int'(audio), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_active_chan", int'(active_chan), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_done_chan", int'(done_chan), 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Tone shape: div=3, tick every cycle -> 4 cycles high, 4 low
        set_cfg(3, 20, 'hFF, 3);
        done_q.delete();
        cyc(4'b1000, 1'b0, 1'b1, 1'b0);
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            cyc('0, 1'b0, 1'b1, 1'b0);
            if (audio) found = 1;
        end
        chk("tone_rise", int'(found), 1);
        shape = '0;
        shape[0] = audio;
        for (int j = 1; j < 8; j++) begin
            cyc('0, 1'b0, 1'b1, 1'b0);
            shape[j] = audio;
        end
        chk("tone_shape", int'(shape), 'h0F);
        for (int k = 0; k < 400 && busy; k++) cyc('0, (k % 8) == 7, 1'b1, 1'b0);

        // Preemption of ch2 by ch0, with ch3 left pending
        set_cfg(2, 15, 'hFF, 0);
        set_cfg(0, 5, 'hFF, 2);
        set_cfg(3, 4, 'hFF, 0);
        done_q.delete();
        cyc(4'b0100, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 24; k++) cyc('0, (k % 8) == 7, 1'b1, 1'b0);
        cyc(4'b1001, 1'b0, 1'b1, 1'b0);
        chk("preempt_chan", int'(active_chan), 0);
        chk("preempt_busy", int'(busy), 1);
        gap_frames = 0;
        for (int k = 0; k < 300; k++) begin
            if (done_q.size() == 1 && active_chan != 2'd3 && (k % 8) == 7) gap_frames++;
            cyc('0, (k % 8) == 7, 1'b1, 1'b0);
            if (done_q.size() == 2 && !busy) break;
        end
        chk("preempt_done_cnt", done_q.size(), 2);
        if (done_q.size() == 2) begin
            chk("preempt_done0", done_q[0], 0);
            chk("preempt_done1", done_q[1], 3);
        end
        chk("preempt_gap_frames", gap_frames, 1);

        // Re-trigger of ch1 after 10 frames: 25 lit frames in total
        set_cfg(1, 15, 'hFF, 0);
        done_q.delete();
        att_frames = 0;
        cyc(4'b0010, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 80; k++) cyc('0, (k % 8) == 7, 1'b1, 1'b0);
        cyc(4'b0010, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 300; k++) begin
            cyc('0, (k % 8) == 7, 1'b1, 1'b0);
            if (done_q.size() > 0 && !busy) break;
        end
        chk("retrig_att_frames", att_frames, 25);
        chk("retrig_done_cnt", done_q.size(), 1);

        // Reset in the middle of an alert
        set_cfg(2, 10, 'hFF, 1);
        done_q.delete();
        cyc(4'b0100, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) cyc('0, (k % 8) == 7, 1'b1, 1'b0);
        chk("pre_rst_busy", int'(busy), 1);
        cyc('0, 1'b1, 1'b1, 1'b1);
        chk("midrst_attention", int'(attention), 0);
        chk("midrst_audio", int'(audio), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_active_chan", int'(active_chan), 0);
        chk("midrst_done", int'(done), 0);
        for (int k = 0; k < 40; k++) cyc('0, (k % 8) == 7, 1'b1, 1'b0);
        chk("midrst_no_done", done_q.size(), 0);
        chk("midrst_idle", int'(busy), 0);

        // Start coinciding with a frame pulse still plays the full duration
        set_cfg(2, 3, 'hFF, 0);
        done_q.delete();
        cyc(4'b0100, 1'b0, 1'b0, 1'b0);
        cyc('0, 1'b1, 1'b0, 1'b0);
        nfr = 0;
        for (int k = 0; k < 100; k++) begin
            if ((k % 4) == 3) nfr++;
            cyc('0, (k % 4) == 3, 1'b0, 1'b0);
            if (done_q.size() > 0) break;
        end
        chk("startframe_frames", nfr, 3);
        chk("startframe_done_chan", (done_q.size() > 0) ? done_q[0] : -1, 2);

        // Randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            logic [NCHAN-1:0] r;
            if ($urandom_range(0, 15) == 0)
                set_cfg($urandom_range(0, NCHAN - 1), $urandom_range(0, 6),
                        $urandom_range(0, 255), $urandom_range(0, 4));
            for (int i = 0; i < NCHAN; i++) r[i] = ($urandom_range(0, 24) == 0);
            cyc(r, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 599) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
